// File: rtl/tranif_or3.sv
// ---------------------------------------------------------------------------
// tranif_or3
//
// Registered switch-level model of an N-input OR gate. A series chain of
// tranif0-style pull-up switches and a parallel bank of tranif1-style
// pull-down switches drive an internal node. An output inverter on that node
// restores OR polarity.
//
// Each switch has a fault-injection mask. The resolved node state is reported
// alongside the logic result, so the block can serve as a switch-level
// reference model.
//
// Parameters:
//   N           number of OR inputs; legal range 2..16
//
// Ports:
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   in_valid    sample x and both fault masks this cycle
//   x           OR inputs; x[i] gates pull-up switch i and pull-down switch i
//   pu_open     bit i forces pull-up switch i stuck-open
//   pd_short    bit i forces pull-down switch i stuck-closed
//   out_valid   one-cycle strobe: y, nor_node, node_state and fault updated
//   y           registered OR result (inverter output)
//   nor_node    registered logic value of the internal node
//   node_state  00 driven low, 01 driven high, 10 floating, 11 contention
//   fault       last accepted sample left the node floating or in contention
// ---------------------------------------------------------------------------
module tranif_or3 #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] x,
    input  logic [N-1:0] pu_open,
    input  logic [N-1:0] pd_short,
    output logic         out_valid,
    output logic         y,
    output logic         nor_node,
    output logic [1:0]   node_state,
    output logic         fault
);

    localparam logic [1:0] ST_LOW   = 2'b00;
    localparam logic [1:0] ST_HIGH  = 2'b01;
    localparam logic [1:0] ST_FLOAT = 2'b10;
    localparam logic [1:0] ST_CONT  = 2'b11;

    logic [N-1:0] pu_on;
    logic [N-1:0] pd_on;
    logic         pu_path;
    logic         pd_path;

    logic [1:0]   state_nxt;
    logic         node_nxt;
    logic         y_nxt;

    // Per-switch conduction. A stuck-open pull-up can only break the chain.
    // A stuck-closed pull-down can only add a path to ground.
    assign pu_on = ~x & ~pu_open;
    assign pd_on = x | pd_short;

    // The pull-up switches are in series, so every one of them must conduct.
    // The pull-down switches are in parallel, so any one of them is enough.
    assign pu_path = &pu_on;
    assign pd_path = |pd_on;

    always_comb begin
        state_nxt = ST_HIGH;
        node_nxt  = nor_node;
        y_nxt     = y;
        case ({pu_path, pd_path})
            2'b10: begin
                state_nxt = ST_HIGH;
                node_nxt  = 1'b1;
                y_nxt     = 1'b0;
            end
            2'b01: begin
                state_nxt = ST_LOW;
                node_nxt  = 1'b0;
                y_nxt     = 1'b1;
            end
            2'b11: begin
                // The pull-down network is modelled as the stronger one,
                // so the node fights its way to 0.
                state_nxt = ST_CONT;
                node_nxt  = 1'b0;
                y_nxt     = 1'b1;
            end
            default: begin
                // Floating node: charge storage keeps the last value, and
                // the inverter output keeps following it.
                state_nxt = ST_FLOAT;
                node_nxt  = nor_node;
                y_nxt     = y;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            y          <= 1'b0;
            nor_node   <= 1'b1;
            node_state <= ST_HIGH;
            fault      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y          <= y_nxt;
                nor_node   <= node_nxt;
                node_state <= state_nxt;
                fault      <= state_nxt[1];
            end
        end
    end

endmodule

// File: tb/tb_tranif_or3.sv
// ---------------------------------------------------------------------------
// tb_tranif_or3
//
// Self-checking bench for tranif_or3 with N=3.
//
// Each driven sample pushes its predicted outputs onto a scoreboard queue.
// When out_valid appears, the oldest prediction is popped and compared with
// the outputs.
// ---------------------------------------------------------------------------
module tb_tranif_or3;

    localparam int N = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] x;
    logic [N-1:0] pu_open;
    logic [N-1:0] pd_short;
    logic         out_valid;
    logic         y;
    logic         nor_node;
    logic [1:0]   node_state;
    logic         fault;

    typedef struct packed {
        logic       y;
        logic       node;
        logic [1:0] st;
        logic       flt;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    logic m_node;
    logic m_y;

    tranif_or3 #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .x          (x),
        .pu_open    (pu_open),
        .pd_short   (pd_short),
        .out_valid  (out_valid),
        .y          (y),
        .nor_node   (nor_node),
        .node_state (node_state),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Switch-level prediction, evaluated one switch at a time. It also updates
    // the model's stored node and output values.
    function automatic exp_t predict(input logic [N-1:0] xv, input logic [N-1:0] pum,
                                     input logic [N-1:0] pdm);
        exp_t e;
        logic up;
        logic dn;
        up = 1'b1;
        dn = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (xv[i] || pum[i]) up = 1'b0;
            if (xv[i] || pdm[i]) dn = 1'b1;
        end
        if (up && !dn) begin
            e.st = 2'b01; m_node = 1'b1; m_y = 1'b0;
        end else if (!up && dn) begin
            e.st = 2'b00; m_node = 1'b0; m_y = 1'b1;
        end else if (up && dn) begin
            e.st = 2'b11; m_node = 1'b0; m_y = 1'b1;
        end else begin
            e.st = 2'b10;
        end
        e.node = m_node;
        e.y    = m_y;
        e.flt  = (e.st == 2'b10) || (e.st == 2'b11);
        return e;
    endfunction

    task automatic cycle(input logic v, input logic [N-1:0] xv, input logic [N-1:0] pum,
                         input logic [N-1:0] pdm);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        x        = xv;
        pu_open  = pum;
        pd_short = pdm;
        if (v) sb.push_back(predict(xv, pum, pdm));
        @(posedge clk);
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, v});
        if (out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk("y",          {31'b0, y},          {31'b0, e.y});
            chk("nor_node",   {31'b0, nor_node},   {31'b0, e.node});
            chk("node_state", {30'b0, node_state}, {30'b0, e.st});
            chk("fault",      {31'b0, fault},      {31'b0, e.flt});
        end else if (!out_valid) begin
            chk("hold_y",    {31'b0, y},        {31'b0, m_y});
            chk("hold_node", {31'b0, nor_node}, {31'b0, m_node});
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_y"},         {31'b0, y},         32'd0);
        chk({tag, "_nor_node"},  {31'b0, nor_node},  32'd1);
        chk({tag, "_state"},     {30'b0, node_state}, 32'd1);
        chk({tag, "_fault"},     {31'b0, fault},     32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        m_node   = 1'b1;
        m_y      = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        pu_open  = '0;
        pd_short = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Before any sample is accepted, the outputs keep their reset values.
        cycle(1'b0, 3'b111, '0, '0);

        // Fault-free sweep, back to back.
        for (int i = 0; i < 8; i++) cycle(1'b1, i[N-1:0], '0, '0);

        // A floating node keeps its stored value.
        cycle(1'b1, 3'b000, 3'b000, 3'b000);
        cycle(1'b1, 3'b000, 3'b010, 3'b000);
        chk("float_state", {30'b0, node_state}, 32'd2);

        // Contention resolves low.
        cycle(1'b1, 3'b000, 3'b000, 3'b001);
        chk("cont_state", {30'b0, node_state}, 32'd3);

        // The input already opens the chain, so the stuck-open masks are hidden.
        cycle(1'b1, 3'b100, 3'b111, 3'b000);
        chk("masked_fault", {31'b0, fault}, 32'd0);

        // Float after contention keeps node=0 and y=1.
        cycle(1'b1, 3'b000, 3'b100, 3'b000);

        // Random mix with occasional fault masks and idle cycles.
        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] rx;
            logic [N-1:0] rpu;
            logic [N-1:0] rpd;
            rx  = N'($urandom_range(0, 7));
            rpu = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0;
            rpd = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0;
            cycle(1'($urandom_range(0, 4) != 0), rx, rpu, rpd);
        end

        // Reset mid-stream: the pending sample is discarded.
        @(negedge clk);
        in_valid = 1'b1;
        x        = 3'b101;
        pu_open  = '0;
        pd_short = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        m_node = 1'b1;
        m_y    = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("mid_rst_edge");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Hold: one sample, then three idle cycles.
        cycle(1'b1, 3'b010, '0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 3'b000, 3'b111, 3'b000);
            chk("hold_y1", {31'b0, y}, 32'd1);
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tranif_or3.md
Name: tranif_or3

Overview:
- Synthesizable, registered model of an N-input OR gate built from bidirectional switch primitives.
- Pull-up network: tranif0-style switches (conduct when gate=0) in series from VCC to an internal node.
- Pull-down network: tranif1-style switches (conduct when gate=1) in parallel from the node to GND.
- An output inverter (tranif1 to GND, tranif0 to VCC) restores the OR polarity.
- Per-switch fault-injection masks and node-state reporting make the block usable as a switch-level reference inside logic-verification environments.

Parameters:
- N, 3, number of OR inputs; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  sample x and the fault masks this cycle
- x  input  N  OR inputs; x[i] drives the gates of pull-up switch i and pull-down switch i
- pu_open  input  N  bit i=1 forces pull-up switch i non-conducting (stuck-open)
- pd_short  input  N  bit i=1 forces pull-down switch i conducting (stuck-closed)
- out_valid  output  1  y, nor_node, node_state and fault are updated this cycle
- y  output  1  registered OR result (inverter output)
- nor_node  output  1  registered logic value of the internal node
- node_state  output  2  00 driven low, 01 driven high, 10 floating, 11 contention
- fault  output  1  node was floating or in contention on the last accepted sample

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, y=0, nor_node=1, node_state=01, fault=0. Outputs stay at these values until the first accepted sample.
- Switch rules:
  - pull-up switch i conducts iff x[i]=0 and pu_open[i]=0.
  - pull-down switch i conducts iff x[i]=1 or pd_short[i]=1.
- Path evaluation:
  - pu_path = AND of all N pull-up conduct terms (series chain).
  - pd_path = OR of all N pull-down conduct terms (parallel).
- Node resolution:
  - pu_path=1, pd_path=0: state 01, node=1.
  - pu_path=0, pd_path=1: state 00, node=0.
  - both 0: state 10 (float). Node keeps its previously registered value (charge storage).
  - both 1: state 11 (contention). Node resolves to 0; pull-down is stronger.
- Output inverter: y = ~node for states 00, 01 and 11. For state 10, y holds its previous registered value.
- fault = 1 iff state is 10 or 11.
- Latency: exactly 1 cycle.
  - A sample accepted with in_valid=1 at edge k appears on the outputs after edge k, with out_valid=1 for that one cycle.
  - out_valid=0 in cycles with no accepted sample; all other outputs hold.
- Back-to-back in_valid is supported at full rate. There is no backpressure.
- Fault-free (masks all 0): node = NOR(x), y = OR(x), state never 10 or 11, fault=0.
- Reset asserted mid-stream discards the pending sample; outputs go to their reset values immediately.
- Masks are sampled only with in_valid, like x.

Test Plan:
- Fault-free sweep: apply x=0..7 (N=3) with in_valid each cycle → y: 0,1,1,1,1,1,1,1; nor_node = ~y; node_state 01 for x=0, otherwise 00; fault=0; out_valid one cycle after each sample.
- Float: x=0 → y=0. Then x=0 with pu_open=3'b010 → node_state=10, fault=1, y stays 0, nor_node stays 1.
- Contention: x=0, pd_short=3'b001 → node_state=11, nor_node=0, y=1, fault=1.
- Stuck faults masked by inputs: x=3'b100, pu_open=3'b111 → node_state=00, y=1, fault=0.
- Reset mid-operation: in_valid=1, x=3'b101, then drop rst_n before the next edge → out_valid=0, y=0, nor_node=1, node_state=01 immediately. The held sample never appears.
- Hold behaviour: x=3'b010 accepted, then in_valid=0 for 3 cycles → out_valid=0, y stays 1 throughout.
